// File: rtl/phase1_stage_controller.sv
// Phase 1 puzzle sequencer: routes keypad and display to one puzzle at a time,
// tracks lives and a BCD countdown, and reports phase done / game over.
module phase1_stage_controller #(
    parameter int         NUM_PUZZLES = 3,
    parameter int         MAX_LIVES   = 3,
    parameter logic [7:0] TIME_LIMIT  = 8'h99,
    parameter int         TICK_DIV    = 50000000,
    parameter int         HOLD_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      key_valid,
    input  logic [3:0]                key_value,
    input  logic [32*NUM_PUZZLES-1:0] puz_seg_data,
    input  logic [8*NUM_PUZZLES-1:0]  puz_led,
    input  logic [NUM_PUZZLES-1:0]    puz_clear,
    input  logic [NUM_PUZZLES-1:0]    puz_fail,
    output logic [NUM_PUZZLES-1:0]    puz_enable,
    output logic [NUM_PUZZLES-1:0]    puz_key_valid,
    output logic [3:0]                key_value_out,
    output logic [31:0]               seg_data,
    output logic [7:0]                led_out,
    output logic [3:0]                lives,
    output logic [7:0]                time_left,
    output logic                      phase_done,
    output logic                      game_over
);

    localparam int IW = (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_PUZZLES - 1);
    localparam logic [3:0]    LIVES_INIT = 4'(MAX_LIVES);

    typedef enum logic [2:0] {
        IDLE, PLAY, CLEAR_HOLD, FAIL_HOLD, DONE, OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [3:0]             lives_q, lives_d;
    logic [7:0]             time_q, time_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [NUM_PUZZLES-1:0] en_q, en_d;
    logic                   done_q, over_q;

    logic [15:0] slot_seg;
    logic [7:0]  slot_led;
    logic        slot_clr;
    logic        slot_fail;
    logic        tick;
    logic [7:0]  time_dec;
    logic        unused_seg;

    // upper half of each puzzle display word is never shown
    assign unused_seg = ^puz_seg_data;

    // BCD countdown by one second, saturating at 00
    function automatic logic [7:0] bcd_dec(input logic [7:0] t);
        if (t == 8'h00)
            return 8'h00;
        else if (t[3:0] == 4'h0)
            return {t[7:4] - 4'd1, 4'h9};
        else
            return {t[7:4], t[3:0] - 4'd1};
    endfunction

    // pick the active slot's display, LED and event lines
    always_comb begin
        slot_seg  = '0;
        slot_led  = '0;
        slot_clr  = 1'b0;
        slot_fail = 1'b0;
        for (int k = 0; k < NUM_PUZZLES; k++) begin
            if (idx_q == IW'(k)) begin
                slot_seg  = puz_seg_data[32*k +: 16];
                slot_led  = puz_led[8*k +: 8];
                slot_clr  = puz_clear[k];
                slot_fail = puz_fail[k];
            end
        end
    end

    assign tick     = (pre_q == PRE_LAST);
    assign time_dec = bcd_dec(time_q);

    // next-state logic: start, puzzle events, timer and hold exits
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lives_d = lives_q;
        time_d  = time_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE, DONE, OVER: begin
                if (start) begin
                    state_d = PLAY;
                    idx_d   = '0;
                    lives_d = LIVES_INIT;
                    time_d  = TIME_LIMIT;
                    pre_d   = '0;
                    hold_d  = '0;
                end
            end
            PLAY: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (slot_clr) begin
                    state_d = CLEAR_HOLD;
                    hold_d  = '0;
                end else if (slot_fail) begin
                    if (lives_q > 4'd1) begin
                        lives_d = lives_q - 4'd1;
                        state_d = FAIL_HOLD;
                        hold_d  = '0;
                    end else begin
                        lives_d = 4'd0;
                        state_d = OVER;
                    end
                end else if (tick) begin
                    time_d = time_dec;
                    if (time_dec == 8'h00)
                        state_d = OVER;
                end
            end
            CLEAR_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = PLAY;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            FAIL_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = PLAY;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // one-hot enable for the slot that will be active next cycle
    always_comb begin
        en_d = '0;
        for (int k = 0; k < NUM_PUZZLES; k++)
            en_d[k] = (state_d == PLAY) && (idx_d == IW'(k));
    end

    // state, counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lives_q <= '0;
            time_q  <= '0;
            pre_q   <= '0;
            hold_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            en_q    <= en_d;
            done_q  <= (state_d == DONE);
            over_q  <= (state_d == OVER);
        end
    end

    // display and LED muxing by state
    always_comb begin
        led_out  = 8'h00;
        seg_data = 32'h0;
        unique case (state_q)
            PLAY: begin
                led_out  = slot_led;
                seg_data = {time_q, lives_q, 4'(idx_q) + 4'd1, slot_seg};
            end
            CLEAR_HOLD: begin
                led_out  = 8'hFF;
                seg_data = {time_q, lives_q, 4'(idx_q) + 4'd1, slot_seg};
            end
            FAIL_HOLD: begin
                led_out  = 8'h0F;
                seg_data = {time_q, lives_q, 4'(idx_q) + 4'd1, slot_seg};
            end
            DONE: begin
                led_out  = 8'hFF;
                seg_data = {time_q, 24'h0};
            end
            OVER:    seg_data = {8'h00, lives_q, 20'h0};
            default: seg_data = 32'h0;
        endcase
    end

    // key 9 is reserved for system reset and never reaches a puzzle
    assign puz_key_valid = (state_q == PLAY && key_valid && key_value != 4'd9)
                         ? en_q : '0;
    assign key_value_out = key_value;
    assign puz_enable    = en_q;
    assign lives         = lives_q;
    assign time_left     = time_q;
    assign phase_done    = done_q;
    assign game_over     = over_q;

endmodule

// File: tb/tb_phase1_stage_controller.sv
// Directed bench for phase1_stage_controller: vector table for the main
// sequencing plus hand-written reset, timer and restart sequences.
module tb_phase1_stage_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [95:0] puz_seg_data;
    logic [23:0] puz_led;
    logic [2:0]  puz_clear;
    logic [2:0]  puz_fail;
    logic [2:0]  puz_enable;
    logic [2:0]  puz_key_valid;
    logic [3:0]  key_value_out;
    logic [31:0] seg_data;
    logic [7:0]  led_out;
    logic [3:0]  lives;
    logic [7:0]  time_left;
    logic        phase_done;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    phase1_stage_controller #(
        .NUM_PUZZLES(3),
        .MAX_LIVES  (3),
        .TIME_LIMIT (8'h12),
        .TICK_DIV   (4),
        .HOLD_CYCLES(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_valid    (key_valid),
        .key_value    (key_value),
        .puz_seg_data (puz_seg_data),
        .puz_led      (puz_led),
        .puz_clear    (puz_clear),
        .puz_fail     (puz_fail),
        .puz_enable   (puz_enable),
        .puz_key_valid(puz_key_valid),
        .key_value_out(key_value_out),
        .seg_data     (seg_data),
        .led_out      (led_out),
        .lives        (lives),
        .time_left    (time_left),
        .phase_done   (phase_done),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        kv;
        logic [3:0]  kval;
        logic [2:0]  clr;
        logic [2:0]  fl;
        logic [2:0]  en;
        logic [2:0]  pkv;
        logic [7:0]  led;
        logic [3:0]  lv;
        logic [7:0]  tl;
        logic        dn;
        logic        ov;
        logic [31:0] seg;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(
        input logic st, input logic kv, input logic [3:0] kval,
        input logic [2:0] clr, input logic [2:0] fl,
        input logic [2:0] en, input logic [2:0] pkv, input logic [7:0] led,
        input logic [3:0] lv, input logic [7:0] tl,
        input logic dn, input logic ov, input logic [31:0] seg);
        vec_t v;
        v.st = st; v.kv = kv; v.kval = kval; v.clr = clr; v.fl = fl;
        v.en = en; v.pkv = pkv; v.led = led; v.lv = lv; v.tl = tl;
        v.dn = dn; v.ov = ov; v.seg = seg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " en"},   32'(puz_enable), 32'h0);
        chk({nm, " pkv"},  32'(puz_key_valid), 32'h0);
        chk({nm, " kvo"},  32'(key_value_out), 32'h0);
        chk({nm, " seg"},  seg_data, 32'h0);
        chk({nm, " led"},  32'(led_out), 32'h0);
        chk({nm, " lives"}, 32'(lives), 32'h0);
        chk({nm, " tl"},   32'(time_left), 32'h0);
        chk({nm, " done"}, 32'(phase_done), 32'h0);
        chk({nm, " over"}, 32'(game_over), 32'h0);
    endtask

    initial begin
        logic [7:0] prev_tl;
        logic [7:0] exp_tl;
        int         rem;

        tbl[0]  = mk(1,0,0,3'b000,3'b000, 3'b000,3'b000,8'h00,0,8'h00,0,0,32'h0);
        tbl[1]  = mk(0,1,5,3'b000,3'b000, 3'b001,3'b001,8'hA0,3,8'h12,0,0,32'h1231B000);
        tbl[2]  = mk(0,1,9,3'b000,3'b000, 3'b001,3'b000,8'hA0,3,8'h12,0,0,32'h1231B000);
        tbl[3]  = mk(0,0,0,3'b010,3'b100, 3'b001,3'b000,8'hA0,3,8'h12,0,0,32'h1231B000);
        tbl[4]  = mk(0,0,0,3'b001,3'b001, 3'b001,3'b000,8'hA0,3,8'h12,0,0,32'h1231B000);
        tbl[5]  = mk(0,1,5,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1231B000);
        tbl[6]  = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1231B000);
        tbl[7]  = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1231B000);
        tbl[8]  = mk(0,1,3,3'b010,3'b000, 3'b010,3'b010,8'hA1,3,8'h12,0,0,32'h1232B001);
        tbl[9]  = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1232B001);
        tbl[10] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1232B001);
        tbl[11] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1232B001);
        tbl[12] = mk(0,0,0,3'b100,3'b000, 3'b100,3'b000,8'hA2,3,8'h12,0,0,32'h1233B002);
        tbl[13] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1233B002);
        tbl[14] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1233B002);
        tbl[15] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,0,0,32'h1233B002);
        tbl[16] = mk(0,1,5,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,1,0,32'h12000000);
        tbl[17] = mk(1,0,0,3'b000,3'b000, 3'b000,3'b000,8'hFF,3,8'h12,1,0,32'h12000000);
        tbl[18] = mk(0,0,0,3'b000,3'b001, 3'b001,3'b000,8'hA0,3,8'h12,0,0,32'h1231B000);
        tbl[19] = mk(1,1,5,3'b000,3'b000, 3'b000,3'b000,8'h0F,2,8'h12,0,0,32'h1221B000);
        tbl[20] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'h0F,2,8'h12,0,0,32'h1221B000);
        tbl[21] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'h0F,2,8'h12,0,0,32'h1221B000);
        tbl[22] = mk(1,0,0,3'b000,3'b001, 3'b001,3'b000,8'hA0,2,8'h12,0,0,32'h1221B000);
        tbl[23] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'h0F,1,8'h12,0,0,32'h1211B000);
        tbl[24] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'h0F,1,8'h12,0,0,32'h1211B000);
        tbl[25] = mk(0,0,0,3'b000,3'b000, 3'b000,3'b000,8'h0F,1,8'h12,0,0,32'h1211B000);
        tbl[26] = mk(0,0,0,3'b000,3'b001, 3'b001,3'b000,8'hA0,1,8'h12,0,0,32'h1211B000);
        tbl[27] = mk(0,1,5,3'b000,3'b000, 3'b000,3'b000,8'h00,0,8'h12,0,1,32'h0);
        tbl[28] = mk(1,0,0,3'b000,3'b000, 3'b000,3'b000,8'h00,0,8'h12,0,1,32'h0);
        tbl[29] = mk(0,0,0,3'b000,3'b000, 3'b001,3'b000,8'hA0,3,8'h12,0,0,32'h1231B000);

        puz_seg_data = {32'hDEA2B002, 32'hDEA1B001, 32'hDEA0B000};
        puz_led      = {8'hA2, 8'hA1, 8'hA0};
        start     = 1'b0;
        key_valid = 1'b0;
        key_value = 4'd0;
        puz_clear = 3'b000;
        puz_fail  = 3'b000;
        rst_n     = 1'b1;

        // reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        #2 rst_n = 1'b1;
        step();

        // table-driven sequencing: clears, keys, fails, done, over, restart
        for (int i = 0; i < 30; i++) begin
            start     = tbl[i].st;
            key_valid = tbl[i].kv;
            key_value = tbl[i].kval;
            puz_clear = tbl[i].clr;
            puz_fail  = tbl[i].fl;
            #1;
            chk($sformatf("r%0d en", i),    32'(puz_enable),    32'(tbl[i].en));
            chk($sformatf("r%0d pkv", i),   32'(puz_key_valid), 32'(tbl[i].pkv));
            chk($sformatf("r%0d kvo", i),   32'(key_value_out), 32'(tbl[i].kval));
            chk($sformatf("r%0d led", i),   32'(led_out),       32'(tbl[i].led));
            chk($sformatf("r%0d lives", i), 32'(lives),         32'(tbl[i].lv));
            chk($sformatf("r%0d tl", i),    32'(time_left),     32'(tbl[i].tl));
            chk($sformatf("r%0d done", i),  32'(phase_done),    32'(tbl[i].dn));
            chk($sformatf("r%0d over", i),  32'(game_over),     32'(tbl[i].ov));
            chk($sformatf("r%0d seg", i),   seg_data,           tbl[i].seg);
            step();
        end
        start     = 1'b0;
        key_valid = 1'b0;
        key_value = 4'd0;
        puz_clear = 3'b000;
        puz_fail  = 3'b000;

        // asynchronous reset in the middle of CLEAR_HOLD
        puz_clear = 3'b001;
        step();
        puz_clear = 3'b000;
        #1;
        chk("hold led", 32'(led_out), 32'hFF);
        rst_n = 1'b0;
        #1;
        chk_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // countdown from 12 to 00, then OVER
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tmr start", 32'(time_left), 32'h12);
        prev_tl = 8'h12;
        for (int n = 1; n <= 12; n++) begin
            repeat (3) step();
            chk($sformatf("tmr hold %0d", n), 32'(time_left), 32'(prev_tl));
            step();
            rem    = 12 - n;
            exp_tl = 8'((rem / 10) * 16 + (rem % 10));
            chk($sformatf("tmr %0d", n), 32'(time_left), 32'(exp_tl));
            chk($sformatf("tmr over %0d", n), 32'(game_over), 32'(n == 12));
            prev_tl = exp_tl;
        end
        chk("over seg", seg_data, 32'h00300000);
        chk("over en", 32'(puz_enable), 32'h0);

        // restart from OVER
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst lives", 32'(lives), 32'd3);
        chk("rst tl", 32'(time_left), 32'h12);
        chk("rst over", 32'(game_over), 32'h0);
        chk("rst en", 32'(puz_enable), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
